// File: rtl/bcd_to_bin_seq.sv
// Sequential three-digit packed BCD to binary converter (reverse double-dabble).
// Performs one shift-and-correct step per clock and uses a start/done handshake.
module bcd_to_bin_seq #(
    parameter int unsigned OUT_W = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       H,
    input  logic [3:0]       T,
    input  logic [3:0]       O,
    output logic             ready,
    output logic             done,
    output logic [OUT_W-1:0] bin,
    output logic             err
);

    localparam int unsigned CNT_W = (OUT_W > 1) ? $clog2(OUT_W) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [11:0]        bcd_q, bcd_sh, bcd_tmp;
    logic [OUT_W-1:0]   res_q, res_sh;
    logic [CNT_W-1:0]   cnt_q;
    logic               bad_q;
    logic [OUT_W-1:0]   bin_q;
    logic               err_q;
    logic               accept, digit_bad, last;

    assign accept    = start && ((state_q == IDLE) || (state_q == DONE));
    assign digit_bad = (H > 4'd9) || (T > 4'd9) || (O > 4'd9);
    // A bad-digit request spends exactly one cycle in SHIFT, so err appears two cycles after start.
    assign last      = (state_q == SHIFT) && (bad_q || (cnt_q == CNT_W'(OUT_W - 1)));

    always_comb begin
        res_sh  = {bcd_q[0], res_q[OUT_W-1:1]};
        bcd_tmp = {1'b0, bcd_q[11:1]};
        bcd_sh  = bcd_tmp;
        for (int unsigned i = 0; i < 3; i++) begin
            if (bcd_tmp[4*i +: 4] >= 4'd8)
                bcd_sh[4*i +: 4] = bcd_tmp[4*i +: 4] - 4'd3;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = SHIFT;
            SHIFT:   if (last)   state_d = DONE;
            DONE:    state_d = accept ? SHIFT : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ready = (state_q == IDLE) || (state_q == DONE);
        done  = (state_q == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcd_q <= '0;
            res_q <= '0;
            cnt_q <= '0;
            bad_q <= 1'b0;
            bin_q <= '0;
            err_q <= 1'b0;
        end else if (accept) begin
            bcd_q <= {H, T, O};
            res_q <= '0;
            cnt_q <= '0;
            bad_q <= digit_bad;
        end else if (state_q == SHIFT) begin
            bcd_q <= bcd_sh;
            res_q <= res_sh;
            cnt_q <= cnt_q + 1'b1;
            if (last) begin
                bin_q <= bad_q ? '0 : res_sh;
                err_q <= bad_q;
            end
        end
    end

    assign bin = bin_q;
    assign err = err_q;

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Directed self-checking bench for bcd_to_bin_seq with the default OUT_W of 10.
// Expected values are hand-computed constants or 100*H + 10*T + O.
module tb_bcd_to_bin_seq;

    localparam int unsigned OUT_W = 10;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [3:0]       H, T, O;
    logic             ready, done, err;
    logic [OUT_W-1:0] bin;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    bcd_to_bin_seq #(.OUT_W(OUT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .H     (H),
        .T     (T),
        .O     (O),
        .ready (ready),
        .done  (done),
        .bin   (bin),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Issues one single-cycle start and returns the number of cycles until done is seen.
    task automatic convert(input logic [3:0] h, input logic [3:0] t, input logic [3:0] o,
                           output int unsigned lat);
        @(negedge clk);
        H = h; T = t; O = o; start = 1'b1;
        @(posedge clk);
        #1;
        check("ready_drop", ready, 0);
        start = 1'b0;
        lat = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            lat++;
            if (done) break;
        end
        if (!done) check("done_timeout", 0, 1);
    endtask

    int unsigned lat;
    int unsigned cnt;
    int unsigned pulses;
    int unsigned exp_val;
    int unsigned vals [7] = '{0, 8, 10, 99, 100, 128, 999};
    int unsigned b2b [3] = '{123, 456, 705};

    initial begin
        rst_n = 1'b0; start = 1'b0; H = '0; T = '0; O = '0;
        #12;
        check("rst_bin", bin, 0);
        check("rst_err", err, 0);
        check("rst_done", done, 0);
        check("rst_ready", ready, 1);
        @(negedge clk);
        rst_n = 1'b1;

        convert(4'd2, 4'd5, 4'd5, lat);
        check("lat_255", lat, 11);
        check("bin_255", bin, 255);
        check("err_255", err, 0);
        repeat (3) @(negedge clk);
        check("hold_bin", bin, 255);
        check("hold_done", done, 0);
        check("hold_ready", ready, 1);

        foreach (vals[k]) begin
            convert(4'(vals[k] / 100), 4'((vals[k] / 10) % 10), 4'(vals[k] % 10), lat);
            check("sweep_bin", bin, vals[k]);
            check("sweep_err", err, 0);
            check("sweep_lat", lat, 11);
        end
        check("bin_999_hex", bin, 32'h3E7);

        convert(4'd0, 4'hA, 4'd0, lat);
        check("bad_lat", lat, 2);
        check("bad_err", err, 1);
        check("bad_bin", bin, 0);
        @(negedge clk);
        check("bad_err_held", err, 1);
        convert(4'd0, 4'd4, 4'd2, lat);
        check("after_bad_err", err, 0);
        check("after_bad_bin", bin, 42);

        // Start held high; junk digits are driven whenever the converter is busy.
        @(negedge clk);
        H = 4'd1; T = 4'd2; O = 4'd3; start = 1'b1;
        @(posedge clk);
        foreach (b2b[k]) begin
            cnt = 0;
            for (int i = 0; i < 30; i++) begin
                @(negedge clk);
                cnt++;
                if (done) break;
                H = 4'd9; T = 4'd8; O = 4'd7;
            end
            check("b2b_bin", bin, b2b[k]);
            check("b2b_period", cnt, 11);
            if (k < 2) begin
                H = 4'(b2b[k+1] / 100); T = 4'((b2b[k+1] / 10) % 10); O = 4'(b2b[k+1] % 10);
            end else begin
                start = 1'b0;
            end
        end

        convert(4'd4, 4'd0, 4'd9, lat);
        check("pre_rst_bin", bin, 409);
        @(negedge clk);
        H = 4'd7; T = 4'd7; O = 4'd7; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_bin", bin, 0);
        check("midrst_err", err, 0);
        check("midrst_done", done, 0);
        check("midrst_ready", ready, 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        check("midrst_no_done", pulses, 0);
        convert(4'd3, 4'd2, 4'd1, lat);
        check("post_rst_bin", bin, 321);
        check("post_rst_lat", lat, 11);

        for (int h = 0; h < 10; h++)
            for (int t = 0; t < 10; t++)
                for (int o = 0; o < 10; o++) begin
                    convert(4'(h), 4'(t), 4'(o), lat);
                    exp_val = 100 * h + 10 * t + o;
                    check("full_bin", bin, exp_val);
                    check("full_err", err, 0);
                end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
